// File: rtl/mem_port_scheduler.sv
// Shared serial memory port: arbitrates prefetcher / load-store commands onto tx pins
// and routes in-order read responses back using a tag queue of outstanding reads.
//
// state      | meaning
// TX_IDLE    | pins quiet, arbitration (ls priority) each cycle
// TX_HEADER  | CMD_BITS/IO_BITS header cycles, LSB slice first
// TX_ADDR    | PAYLOAD_CYCLES cycles of requester address bits
// TX_WDATA   | PAYLOAD_CYCLES cycles of write data (writes only)
// RX_IDLE    | waiting for a non-zero start cycle on rx pins
// RX_PAYLOAD | PAYLOAD_CYCLES cycles routed by the oldest tag
// RX_DISCARD | unexpected response being skipped
module mem_port_scheduler #(
  parameter int IO_BITS         = 2,
  parameter int PAYLOAD_CYCLES  = 8,
  parameter int CMD_BITS        = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   pf_cmd_valid,
  input  logic [CMD_BITS-1:0]                    pf_cmd,
  output logic                                   pf_cmd_started,
  input  logic                                   ls_cmd_valid,
  input  logic [CMD_BITS-1:0]                    ls_cmd,
  input  logic                                   ls_is_write,
  output logic                                   ls_cmd_started,
  input  logic [IO_BITS-1:0]                     pf_tx_data,
  input  logic [IO_BITS-1:0]                     ls_tx_data,
  output logic                                   pf_tx_data_next,
  output logic                                   ls_tx_data_next,
  output logic [$clog2(PAYLOAD_CYCLES):0]        tx_counter,
  output logic                                   tx_active,
  output logic                                   tx_done,
  output logic [IO_BITS-1:0]                     tx_pins,
  input  logic [IO_BITS-1:0]                     rx_pins,
  output logic                                   rx_started,
  output logic                                   rx_active,
  output logic [$clog2(PAYLOAD_CYCLES):0]        rx_counter,
  output logic                                   pf_rx_valid,
  output logic                                   ls_rx_valid,
  output logic                                   pf_rx_done,
  output logic                                   ls_rx_done,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   rx_error
);
  localparam int CNT_W      = $clog2(PAYLOAD_CYCLES) + 1;
  localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam int HDR_CYCLES = CMD_BITS / IO_BITS;
  localparam logic [CNT_W-1:0] LAST_PAY = CNT_W'(PAYLOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_HDR = CNT_W'(HDR_CYCLES - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_HEADER, TX_ADDR, TX_WDATA} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_PAYLOAD, RX_DISCARD} rx_state_t;

  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;

  logic [CMD_BITS-1:0] hdr_q;
  logic [CNT_W-1:0]    tx_cnt, rx_cnt;
  logic                grant_ls, write_q;
  logic                room, ls_elig, pf_elig;
  logic                push, pop, set_err;
  logic [OUT_W-1:0]    push_idx;
  logic                tag_q [MAX_OUTSTANDING];

  assign room     = outstanding < OUT_W'(MAX_OUTSTANDING);
  assign ls_elig  = ls_cmd_valid && (ls_is_write || room);
  assign pf_elig  = pf_cmd_valid && room;
  assign push_idx = outstanding - OUT_W'(pop);

  always_comb begin
    tx_next         = tx_state;
    tx_active       = 1'b0;
    tx_done         = 1'b0;
    tx_pins         = '0;
    tx_counter      = '0;
    pf_cmd_started  = 1'b0;
    ls_cmd_started  = 1'b0;
    pf_tx_data_next = 1'b0;
    ls_tx_data_next = 1'b0;
    push            = 1'b0;
    case (tx_state)
      TX_IDLE:
        if (ls_elig || pf_elig) tx_next = TX_HEADER;
      TX_HEADER: begin
        tx_active = 1'b1;
        tx_pins   = hdr_q[IO_BITS-1:0];
        if (tx_cnt == '0) begin
          ls_cmd_started = grant_ls;
          pf_cmd_started = !grant_ls;
        end
        if (tx_cnt == LAST_HDR) tx_next = TX_ADDR;
      end
      TX_ADDR, TX_WDATA: begin
        tx_active       = 1'b1;
        tx_counter      = tx_cnt;
        tx_pins         = grant_ls ? ls_tx_data : pf_tx_data;
        ls_tx_data_next = grant_ls;
        pf_tx_data_next = !grant_ls;
        if (tx_cnt == LAST_PAY) begin
          if (tx_state == TX_ADDR && write_q) begin
            tx_next = TX_WDATA;
          end else begin
            tx_next = TX_IDLE;
            tx_done = 1'b1;
            push    = !write_q;
          end
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      hdr_q    <= '0;
      tx_cnt   <= '0;
      grant_ls <= 1'b0;
      write_q  <= 1'b0;
    end else begin
      tx_state <= tx_next;
      if (tx_state == TX_IDLE) begin
        tx_cnt <= '0;
        if (ls_elig) begin
          hdr_q    <= ls_cmd;
          grant_ls <= 1'b1;
          write_q  <= ls_is_write;
        end else if (pf_elig) begin
          hdr_q    <= pf_cmd;
          grant_ls <= 1'b0;
          write_q  <= 1'b0;
        end
      end else begin
        tx_cnt <= (tx_next != tx_state) ? '0 : tx_cnt + CNT_W'(1);
        if (tx_state == TX_HEADER) hdr_q <= hdr_q >> IO_BITS;
      end
    end
  end

  // Responses come back in issue order, so the head tag always names the owner.
  always_comb begin
    rx_next     = rx_state;
    rx_started  = 1'b0;
    rx_active   = 1'b0;
    rx_counter  = '0;
    pf_rx_valid = 1'b0;
    ls_rx_valid = 1'b0;
    pf_rx_done  = 1'b0;
    ls_rx_done  = 1'b0;
    pop         = 1'b0;
    set_err     = 1'b0;
    case (rx_state)
      RX_IDLE:
        if (rx_pins != '0) begin
          rx_started = 1'b1;
          if (outstanding != '0) begin
            rx_next = RX_PAYLOAD;
          end else begin
            rx_next = RX_DISCARD;
            set_err = 1'b1;
          end
        end
      RX_PAYLOAD: begin
        rx_active   = 1'b1;
        rx_counter  = rx_cnt;
        pf_rx_valid = !tag_q[0];
        ls_rx_valid = tag_q[0];
        if (rx_cnt == LAST_PAY) begin
          pf_rx_done = !tag_q[0];
          ls_rx_done = tag_q[0];
          pop        = 1'b1;
          rx_next    = RX_IDLE;
        end
      end
      RX_DISCARD:
        if (rx_cnt == LAST_PAY) rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_error    <= 1'b0;
      outstanding <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) tag_q[i] <= 1'b0;
    end else begin
      rx_state    <= rx_next;
      rx_cnt      <= (rx_state == RX_IDLE) ? '0 : rx_cnt + CNT_W'(1);
      rx_error    <= rx_error | set_err;
      outstanding <= outstanding + OUT_W'(push) - OUT_W'(pop);
      if (pop)
        for (int i = 0; i < MAX_OUTSTANDING - 1; i++) tag_q[i] <= tag_q[i+1];
      if (push)
        for (int i = 0; i < MAX_OUTSTANDING; i++)
          if (OUT_W'(i) == push_idx) tag_q[i] <= grant_ls;
    end
  end
endmodule

// File: tb/tb_mem_port_scheduler.sv
// Scoreboard bench for mem_port_scheduler: directed commands and responses push expected
// per-cycle tx/rx records; negedge monitors pop and compare whenever the port is busy.
module tb_mem_port_scheduler;
  logic       clk = 1'b0;
  logic       reset;
  logic       pf_cmd_valid, ls_cmd_valid, ls_is_write;
  logic [3:0] pf_cmd, ls_cmd;
  logic       pf_cmd_started, ls_cmd_started;
  logic [1:0] pf_tx_data, ls_tx_data;
  logic       pf_tx_data_next, ls_tx_data_next;
  logic [3:0] tx_counter, rx_counter;
  logic       tx_active, tx_done;
  logic [1:0] tx_pins, rx_pins;
  logic       rx_started, rx_active;
  logic       pf_rx_valid, ls_rx_valid, pf_rx_done, ls_rx_done;
  logic [1:0] outstanding;
  logic       rx_error;

  always #5 clk = ~clk;

  mem_port_scheduler dut (
    .clk(clk), .reset(reset),
    .pf_cmd_valid(pf_cmd_valid), .pf_cmd(pf_cmd), .pf_cmd_started(pf_cmd_started),
    .ls_cmd_valid(ls_cmd_valid), .ls_cmd(ls_cmd), .ls_is_write(ls_is_write),
    .ls_cmd_started(ls_cmd_started),
    .pf_tx_data(pf_tx_data), .ls_tx_data(ls_tx_data),
    .pf_tx_data_next(pf_tx_data_next), .ls_tx_data_next(ls_tx_data_next),
    .tx_counter(tx_counter), .tx_active(tx_active), .tx_done(tx_done), .tx_pins(tx_pins),
    .rx_pins(rx_pins), .rx_started(rx_started), .rx_active(rx_active),
    .rx_counter(rx_counter), .pf_rx_valid(pf_rx_valid), .ls_rx_valid(ls_rx_valid),
    .pf_rx_done(pf_rx_done), .ls_rx_done(ls_rx_done),
    .outstanding(outstanding), .rx_error(rx_error)
  );

  // Requester shift registers: a word plus a bit-pair index advanced by *_tx_data_next.
  logic [31:0] pf_word = '0, ls_word = '0;
  logic [31:0] pf_sh, ls_sh;
  int pf_idx = 0, ls_idx = 0;
  assign pf_sh      = pf_word >> (2 * pf_idx);
  assign ls_sh      = ls_word >> (2 * ls_idx);
  assign pf_tx_data = pf_sh[1:0];
  assign ls_tx_data = ls_sh[1:0];

  always @(posedge clk) begin
    if (pf_cmd_started) pf_idx <= 0;
    else if (pf_tx_data_next) pf_idx <= pf_idx + 1;
    if (ls_cmd_started) ls_idx <= 0;
    else if (ls_tx_data_next) ls_idx <= ls_idx + 1;
  end

  int checks = 0, failures = 0;
  logic [10:0] tx_q[$];
  logic [7:0]  rx_q[$];
  int cyc, pf_start, ls_start, done_cyc, rxdone_cyc;

  logic [10:0] tx_act;
  logic [7:0]  rx_act;
  logic [24:0] all_out;
  assign tx_act = {pf_cmd_started, ls_cmd_started, pf_tx_data_next, ls_tx_data_next,
                   tx_counter, tx_done, tx_pins};
  assign rx_act = {pf_rx_valid, ls_rx_valid, rx_counter, pf_rx_done, ls_rx_done};
  assign all_out = {pf_cmd_started, ls_cmd_started, pf_tx_data_next, ls_tx_data_next,
                    tx_counter, tx_active, tx_done, tx_pins, rx_started, rx_active,
                    rx_counter, pf_rx_valid, ls_rx_valid, pf_rx_done, ls_rx_done,
                    outstanding, rx_error};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (tx_active || tx_done || pf_cmd_started || ls_cmd_started ||
        pf_tx_data_next || ls_tx_data_next) begin
      if (tx_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL tx_unexpected actual=%0h expected=none (t=%0t)", tx_act, $time);
      end else check("tx_cycle", 64'(tx_act), 64'(tx_q.pop_front()));
    end
    if (rx_active || pf_rx_valid || ls_rx_valid) begin
      if (rx_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rx_unexpected actual=%0h expected=none (t=%0t)", rx_act, $time);
      end else check("rx_cycle", 64'(rx_act), 64'(rx_q.pop_front()));
    end
  end

  function automatic logic [10:0] tx_rec(bit pfs, bit lss, bit pfn, bit lsn, int k, bit d,
                                         logic [1:0] pins);
    return {pfs, lss, pfn, lsn, 4'(k), d, pins};
  endfunction

  task automatic exp_cmd(input bit is_ls, input logic [3:0] cmd, input logic [31:0] word,
                         input bit wr);
    logic [31:0] w;
    tx_q.push_back(tx_rec(!is_ls, is_ls, 1'b0, 1'b0, 0, 1'b0, cmd[1:0]));
    tx_q.push_back(tx_rec(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, cmd[3:2]));
    for (int ph = 0; ph <= (wr ? 1 : 0); ph++)
      for (int k = 0; k < 8; k++) begin
        w = word >> (16 * ph + 2 * k);
        tx_q.push_back(tx_rec(1'b0, 1'b0, !is_ls, is_ls, k,
                              (k == 7) && (ph == (wr ? 1 : 0)), w[1:0]));
      end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (pf_cmd_started) begin pf_cmd_valid = 1'b0; pf_start = cyc; end
    if (ls_cmd_started) begin ls_cmd_valid = 1'b0; ls_start = cyc; end
    if (tx_done) done_cyc = cyc;
    if (pf_rx_done || ls_rx_done) rxdone_cyc = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    step(); n++;
    while ((tx_active || pf_cmd_valid || ls_cmd_valid) && n < budget) begin
      step(); n++;
    end
    if (tx_active || pf_cmd_valid || ls_cmd_valid) begin
      checks++; failures++;
      $display("FAIL wait_idle_timeout actual=busy expected=idle within %0d cycles", budget);
    end
  endtask

  task automatic respond(input bit is_ls);
    for (int k = 0; k < 8; k++) rx_q.push_back({!is_ls, is_ls, 4'(k), (k == 7) && !is_ls, (k == 7) && is_ls});
    rx_pins = 2'b01;
    #1 check("rx_started", 64'(rx_started), 64'd1);
    step();
    repeat (7) begin rx_pins = 2'b11; step(); end
    rx_pins = 2'b00;
    step();
  endtask

  initial begin
    reset = 1'b1; rx_pins = '0;
    pf_cmd_valid = 1'b0; ls_cmd_valid = 1'b0; ls_is_write = 1'b0;
    pf_cmd = '0; ls_cmd = '0;
    cyc = 0; pf_start = -1; ls_start = -1; done_cyc = -1; rxdone_cyc = -1;
    @(negedge clk);
    check("reset_outputs", 64'(all_out), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) step();

    // Single prefetch read
    pf_word = 32'h0000_B4E1; pf_cmd = 4'b1001;
    exp_cmd(1'b0, 4'b1001, pf_word, 1'b0);
    pf_cmd_valid = 1'b1; cyc = 0; pf_start = -1; done_cyc = -1;
    wait_idle(40);
    check("pf_started_cycle", 64'(pf_start), 64'd1);
    check("pf_done_cycle", 64'(done_cyc), 64'd10);
    check("outstanding_after_pf", 64'(outstanding), 64'd1);
    respond(1'b0);
    check("outstanding_after_rsp", 64'(outstanding), 64'd0);

    // Contention: ls read wins, pf read follows after one idle cycle
    ls_word = 32'h0000_5A3C; ls_cmd = 4'b0110; ls_is_write = 1'b0;
    pf_word = 32'h0000_0F0F; pf_cmd = 4'b1100;
    exp_cmd(1'b1, 4'b0110, ls_word, 1'b0);
    exp_cmd(1'b0, 4'b1100, pf_word, 1'b0);
    ls_cmd_valid = 1'b1; pf_cmd_valid = 1'b1; cyc = 0; pf_start = -1; ls_start = -1;
    wait_idle(60);
    check("ls_first_cycle", 64'(ls_start), 64'd1);
    check("pf_after_gap", 64'(pf_start - ls_start), 64'd11);
    check("outstanding_two", 64'(outstanding), 64'd2);

    // Throttle: third read held until a response retires
    pf_word = 32'h0000_C3A5; pf_cmd = 4'b0011;
    exp_cmd(1'b0, 4'b0011, pf_word, 1'b0);
    pf_cmd_valid = 1'b1; pf_start = -1;
    repeat (12) step();
    check("throttle_held", 64'(pf_cmd_valid), 64'd1);
    check("throttle_outstanding", 64'(outstanding), 64'd2);
    respond(1'b1);
    wait_idle(40);
    check("throttle_release", 64'(pf_start - rxdone_cyc), 64'd2);
    check("outstanding_refill", 64'(outstanding), 64'd2);
    respond(1'b0);
    check("outstanding_one", 64'(outstanding), 64'd1);
    respond(1'b0);
    check("outstanding_zero", 64'(outstanding), 64'd0);

    // Write: address then data, no tag
    ls_word = 32'h9C27_13D8; ls_cmd = 4'b1110; ls_is_write = 1'b1;
    exp_cmd(1'b1, 4'b1110, ls_word, 1'b1);
    ls_cmd_valid = 1'b1; cyc = 0; ls_start = -1; done_cyc = -1;
    wait_idle(40);
    ls_is_write = 1'b0;
    check("write_started", 64'(ls_start), 64'd1);
    check("write_done_cycle", 64'(done_cyc), 64'd18);
    check("write_no_outstanding", 64'(outstanding), 64'd0);

    // Unexpected response
    rx_pins = 2'b01;
    #1 check("err_rx_started", 64'(rx_started), 64'd1);
    step();
    rx_pins = 2'b00;
    check("rx_error_set", 64'(rx_error), 64'd1);
    check("discard_not_active", 64'(rx_active), 64'd0);
    repeat (8) step();
    check("rx_error_sticky", 64'(rx_error), 64'd1);
    check("tx_queue_drained", 64'(tx_q.size()), 64'd0);
    check("rx_queue_drained", 64'(rx_q.size()), 64'd0);

    // Reset in the middle of an address phase
    pf_word = 32'h0000_7E81; pf_cmd = 4'b0101;
    exp_cmd(1'b0, 4'b0101, pf_word, 1'b0);
    pf_cmd_valid = 1'b1; cyc = 0;
    repeat (5) step();
    check("mid_addr_active", 64'(tx_active), 64'd1);
    reset = 1'b1;
    step();
    tx_q.delete();
    check("reset_mid_addr", 64'(all_out), 64'd0);
    reset = 1'b0;
    repeat (3) step();
    check("idle_after_reset", 64'(all_out), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
